// File: rtl/i4003_chain_loader_if.sv
// Host-side load port of the i4003 chain loader: request/ready handshake,
// completion pulse and readback of the previous chain contents.
interface i4003_chain_loader_if #(
    parameter int unsigned NBITS = 10
) ();
    logic [NBITS-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             done;
    logic [NBITS-1:0] readback;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  done,
        input  readback
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output done,
        output readback
    );
endinterface

// File: rtl/i4003_chain_loader.sv
// Serially loads a chain of cascaded i4003 shift registers (MSB first) with
// stretched cp phases, captures the previous contents and drives enable.
module i4003_chain_loader #(
    parameter int unsigned SYSCLK_TCY         = 20,
    parameter int unsigned N_CHAIN            = 1,
    parameter int unsigned SETUP_NS           = 100,
    parameter int unsigned CP_HIGH_NS         = 400,
    parameter int unsigned CP_LOW_NS          = 400,
    parameter int unsigned BLANK_DURING_SHIFT = 1
) (
    input  logic                 sysclk,
    input  logic                 poc,
    i4003_chain_loader_if.slave  host,
    input  logic                 display_on,
    input  logic                 chain_serial_out,
    output logic                 cp,
    output logic                 serial_in,
    output logic                 enable
);
    localparam int unsigned NBITS    = 10 * N_CHAIN;
    localparam int unsigned T_SU_RAW = (SETUP_NS   + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int unsigned T_HI_RAW = (CP_HIGH_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int unsigned T_LO_RAW = (CP_LOW_NS  + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int unsigned T_SU     = (T_SU_RAW < 1) ? 1 : T_SU_RAW;
    localparam int unsigned T_HI     = (T_HI_RAW < 1) ? 1 : T_HI_RAW;
    localparam int unsigned T_LO     = (T_LO_RAW < 1) ? 1 : T_LO_RAW;
    localparam int unsigned T_MAX_A  = (T_SU > T_HI) ? T_SU : T_HI;
    localparam int unsigned T_MAX    = (T_MAX_A > T_LO) ? T_MAX_A : T_LO;
    localparam int unsigned CW       = $clog2(T_MAX + 1);
    localparam int unsigned IW       = $clog2(NBITS);
    localparam logic        BLANK    = (BLANK_DURING_SHIFT != 0);

    // The device needs >250 ns in each cp phase to latch internally.
    if (CP_HIGH_NS <= 250 || CP_LOW_NS <= 250) begin : g_bad_cp_timing
        $error("i4003_chain_loader: CP_HIGH_NS and CP_LOW_NS must exceed 250");
    end
    if (N_CHAIN < 1 || N_CHAIN > 4) begin : g_bad_chain
        $error("i4003_chain_loader: N_CHAIN must be 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CP_HIGH,
        S_CP_LOW,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IW-1:0]    r_idx;
    logic [NBITS-1:0] r_data;
    logic [NBITS-1:0] r_readback;
    logic             r_cp;
    logic             r_si;
    logic             r_done;
    logic             r_ready;
    logic             r_loaded;
    logic             r_enable;

    logic             w_to_idle;
    logic             w_busy_nx;
    logic             w_loaded_nx;

    // Enable is computed from next-cycle busy/loaded so it tracks the state edge.
    assign w_to_idle   = (r_state == S_DONE) || ((r_state == S_IDLE) && !host.load_valid);
    assign w_busy_nx   = !w_to_idle;
    assign w_loaded_nx = r_loaded || (r_state == S_DONE);

    always_ff @(posedge sysclk) begin
        if (poc) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_readback <= '0;
            r_cp       <= 1'b0;
            r_si       <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_loaded   <= 1'b0;
            r_enable   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_enable <= display_on && w_loaded_nx && !(BLANK && w_busy_nx);
            case (r_state)
                S_IDLE: begin
                    if (host.load_valid) begin
                        r_data  <= host.load_data;
                        r_idx   <= IW'(NBITS - 1);
                        r_cnt   <= '0;
                        r_si    <= host.load_data[NBITS-1];
                        r_ready <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CW'(T_SU - 1)) begin
                        r_cnt   <= '0;
                        r_cp    <= 1'b1;
                        r_state <= S_CP_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CP_HIGH: begin
                    if (r_cnt == CW'(T_HI - 1)) begin
                        r_cnt   <= '0;
                        r_cp    <= 1'b0;
                        r_state <= S_CP_LOW;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_CP_LOW: begin
                    if (r_cnt == CW'(T_LO - 1)) begin
                        r_cnt      <= '0;
                        r_readback <= {r_readback[NBITS-2:0], chain_serial_out};
                        if (r_idx == '0) begin
                            r_si    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx - IW'(1);
                            r_si    <= r_data[r_idx - IW'(1)];
                            r_state <= S_SETUP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_loaded <= 1'b1;
                    r_ready  <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host.load_ready = r_ready;
    assign host.done       = r_done;
    assign host.readback   = r_readback;
    assign cp              = r_cp;
    assign serial_in       = r_si;
    assign enable          = r_enable;
endmodule

// File: tb/tb_i4003_chain_loader.sv
// Directed bench for i4003_chain_loader: single-device and two-device chains,
// blanking on/off, readback, back-to-back handshake and poc abort.
module tb_i4003_chain_loader;
    localparam int TSU = 5;
    localparam int THI = 20;
    localparam int P   = 45;
    localparam int NB  = 10;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic poc;
    logic display_on;
    int   n_chk = 0;
    int   n_bad = 0;

    i4003_chain_loader_if #(.NBITS(10)) if_a ();
    i4003_chain_loader_if #(.NBITS(20)) if_b ();
    i4003_chain_loader_if #(.NBITS(10)) if_c ();

    logic cp_a, si_a, en_a;
    logic cp_b, si_b, en_b;
    logic cp_c, si_c, en_c;

    // Device models; serial_out presents the far stage as it stood before the latest cp.
    logic [9:0]  sh_a = '0;
    logic        so_a = 1'b0;
    int          pulses_a = 0;
    logic [19:0] sh_b = '0;
    logic        so_b = 1'b0;
    int          pulses_b = 0;
    logic [9:0]  par_a, dev0_b, dev1_b;

    always @(posedge cp_a) begin
        so_a     <= sh_a[9];
        sh_a     <= {sh_a[8:0], si_a};
        pulses_a <= pulses_a + 1;
    end
    always @(posedge cp_b) begin
        so_b     <= sh_b[19];
        sh_b     <= {sh_b[18:0], si_b};
        pulses_b <= pulses_b + 1;
    end
    assign par_a  = en_a ? sh_a        : 10'h000;
    assign dev0_b = en_b ? sh_b[9:0]   : 10'h000;
    assign dev1_b = en_b ? sh_b[19:10] : 10'h000;

    // Instance C mirrors A's host stimulus with blanking disabled.
    assign if_c.load_data  = if_a.load_data;
    assign if_c.load_valid = if_a.load_valid;

    i4003_chain_loader #(.N_CHAIN(1), .BLANK_DURING_SHIFT(1)) dut_a (
        .sysclk(clk), .poc(poc), .host(if_a), .display_on(display_on),
        .chain_serial_out(so_a), .cp(cp_a), .serial_in(si_a), .enable(en_a));
    i4003_chain_loader #(.N_CHAIN(2), .BLANK_DURING_SHIFT(1)) dut_b (
        .sysclk(clk), .poc(poc), .host(if_b), .display_on(display_on),
        .chain_serial_out(so_b), .cp(cp_b), .serial_in(si_b), .enable(en_b));
    i4003_chain_loader #(.N_CHAIN(1), .BLANK_DURING_SHIFT(0)) dut_c (
        .sysclk(clk), .poc(poc), .host(if_c), .display_on(display_on),
        .chain_serial_out(1'b0), .cp(cp_c), .serial_in(si_c), .enable(en_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; accepts d at the next edge and traces every cycle to the first IDLE cycle.
    task automatic run_load(input logic [9:0] d, input logic [9:0] rb_exp, input bit chk_rb,
                            input bit was_loaded, input bit hold, input logic [9:0] next_d);
        int   e_cp, e_si, e_rdy, e_en, e_enc, n_done, done_at, p0, o, b;
        logic cp_e, si_e, rdy_e, en_e, enc_e;
        e_cp = 0; e_si = 0; e_rdy = 0; e_en = 0; e_enc = 0; n_done = 0; done_at = -1;
        p0 = pulses_a;
        if_a.load_data  = d;
        if_a.load_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= NB * P + 2; c++) begin
            @(negedge clk);
            if (!hold) if_a.load_valid = 1'b0;
            o = (c - 1) % P;
            b = (c - 1) / P;
            if (c <= NB * P) begin
                cp_e  = (o >= TSU) && (o < TSU + THI);
                si_e  = d[NB - 1 - b];
                rdy_e = 1'b0;
                en_e  = 1'b0;
                enc_e = display_on & was_loaded;
            end else begin
                cp_e  = 1'b0;
                si_e  = 1'b0;
                rdy_e = (c == NB * P + 2);
                en_e  = rdy_e & display_on;
                enc_e = (c == NB * P + 1) ? (display_on & was_loaded) : display_on;
            end
            if (cp_a !== cp_e) e_cp++;
            if (si_a !== si_e) e_si++;
            if (if_a.load_ready !== rdy_e) e_rdy++;
            if (en_a !== en_e) e_en++;
            if (en_c !== enc_e) e_enc++;
            if (if_a.done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (hold) if_a.load_data = (c == NB * P + 2) ? next_d : 10'(c * 37 + 5);
        end
        check("cp_wave_errs", e_cp, 0);
        check("serial_in_errs", e_si, 0);
        check("load_ready_errs", e_rdy, 0);
        check("enable_blank_errs", e_en, 0);
        check("enable_noblank_errs", e_enc, 0);
        check("done_cycle", done_at, 451);
        check("done_len", n_done, 1);
        check("cp_pulses", pulses_a - p0, 10);
        check("parallel_out", 32'(par_a), 32'(d));
        if (chk_rb) check("readback", 32'(if_a.readback), 32'(rb_exp));
    endtask

    initial begin
        int p0, done_at, en_seen;
        poc             = 1'b1;
        display_on      = 1'b1;
        if_a.load_valid = 1'b0;
        if_a.load_data  = '0;
        if_b.load_valid = 1'b0;
        if_b.load_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_cp", 32'(cp_a), 0);
        check("rst_serial_in", 32'(si_a), 0);
        check("rst_done", 32'(if_a.done), 0);
        check("rst_readback", 32'(if_a.readback), 0);
        check("rst_ready", 32'(if_a.load_ready), 1);
        check("rst_enable", 32'(en_a), 0);
        check("rst_ready_b", 32'(if_b.load_ready), 1);
        poc = 1'b0;
        @(negedge clk);
        check("enable_unloaded", 32'(en_a), 0);

        run_load(10'h2A5, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000);
        run_load(10'h3FF, 10'h2A5, 1'b1, 1'b1, 1'b0, 10'h000);
        run_load(10'h001, 10'h3FF, 1'b1, 1'b1, 1'b0, 10'h000);
        run_load(10'h155, 10'h001, 1'b1, 1'b1, 1'b1, 10'h0AA);
        run_load(10'h0AA, 10'h155, 1'b1, 1'b1, 1'b0, 10'h000);

        display_on = 1'b0;
        @(negedge clk);
        check("enable_display_off", 32'(en_a), 0);
        check("enable_display_off_c", 32'(en_c), 0);
        display_on = 1'b1;
        @(negedge clk);
        check("enable_display_on", 32'(en_a), 1);

        // Abort in the middle of the 4th cp high phase (cycles 141..160).
        p0 = pulses_a;
        if_a.load_data  = 10'h3C3;
        if_a.load_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if_a.load_valid = 1'b0;
        end
        check("abort_pre_cp", 32'(cp_a), 1);
        poc = 1'b1;
        @(negedge clk);
        check("abort_cp", 32'(cp_a), 0);
        check("abort_enable", 32'(en_a), 0);
        check("abort_ready", 32'(if_a.load_ready), 1);
        check("abort_done", 32'(if_a.done), 0);
        poc = 1'b0;
        en_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (en_a !== 1'b0 || en_c !== 1'b0) en_seen++;
        end
        check("abort_enable_held", en_seen, 0);
        check("abort_pulses", pulses_a - p0, 4);
        run_load(10'h1E1, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000);

        // Two-device chain.
        p0 = pulses_b;
        done_at = -1;
        if_b.load_data  = 20'hABCDE;
        if_b.load_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 1200 && done_at < 0; c++) begin
            @(negedge clk);
            if_b.load_valid = 1'b0;
            if (if_b.done === 1'b1) done_at = c;
        end
        check("b_done_cycle", done_at, 901);
        @(negedge clk);
        check("b_ready_after", 32'(if_b.load_ready), 1);
        check("b_pulses", pulses_b - p0, 20);
        check("b_dev0", 32'(dev0_b), 32'h0DE);
        check("b_dev1", 32'(dev1_b), 32'h2AF);
        check("b_enable", 32'(en_b), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
